series_root_finder: RTL and testbench
=====================================

// Module: series_root_finder
// PURPOSE
//  Inverse of the sum-of-series engine. Given S on Data_in, it finds the largest N
//  with 1+2+...+N <= S. It also reports the remainder S - N(N+1)/2 and flags whether
//  S is exactly triangular.
//  It is a multi-cycle datapath plus a Moore controller with a Start/Done handshake.
//  It sits beside the series-sum block, so a sum can be decoded back to its N.
// PARAMETERS
//  W     8   data width of S, N_out and Rem_out (W >= 3)
// PORTS
//  Clk      in   1  single clock, all flops rising-edge
//  Rst_n    in   1  asynchronous, active-low reset
//  Start    in   1  request; sampled only in IDLE
//  Data_in  in   W  S, unsigned; captured on the edge that accepts Start
//  N_out    out  W  result N; held until the next accepted Start
//  Rem_out  out  W  S - N(N+1)/2; held with N_out
//  Exact    out  1  1 when Rem_out == 0; held with N_out
//  Busy     out  1  1 from the accepting edge until the controller returns to IDLE
//  Done     out  1  one-cycle pulse; N_out, Rem_out and Exact are valid while high
// BEHAVIOUR
//  Reset (Rst_n=0, any time, including mid-operation):
//   state=IDLE; R, C, N_out, Rem_out = 0; Exact=0; Busy=0; Done=0.
//   Release is synchronous to the next Clk edge.
//  Registers: R (remainder, W), C (next term, W), N (W).
//   R drives Rem_out and N drives N_out.
//  States:
//   IDLE: Start=1 -> R<=Data_in, C<=1, N<=0, Exact<=0, go to SUB. Otherwise hold.
//   SUB:  if R >= C -> R<=R-C, N<=C, C<=C+1, stay in SUB.
//         else -> Exact<=(R==0), go to DONE.
//   DONE: Done=1, Busy=1, go to IDLE unconditionally.
//  Busy=1 in SUB and DONE. Done=1 only in DONE. Both are Moore, decoded from state.
//  Latency: Done is high in the cycle after rising edge N+2, counting the accepting
//   edge as edge 1. That is N subtracting cycles plus one compare cycle.
//  Start while Busy is ignored; Data_in is not re-sampled.
//   Start held high through DONE is accepted again on the edge that leaves IDLE.
//  Arithmetic:
//   The compare R >= C is unsigned, W bits.
//   R-C never underflows because it is guarded by the compare.
//   C never overflows: C_max = floor(sqrt(2*(2^W-1)))+1 < 2^W for W >= 3.
//  Boundaries:
//   S=0 -> N=0, Rem=0, Exact=1, Done after 2 edges.
//   S=1 -> N=1, Exact=1.
//   S=2^W-1 must terminate with no wrap of C or R.
//  Outputs N_out, Rem_out and Exact change only in SUB/IDLE-accept.
//   They are stable from DONE until the next accepted Start.
//  Invalid state encodings return to IDLE on the next edge with all controls inactive.
// STRUCTURE
//  Package series_pkg:
//   state localparams S_IDLE=2'd0, S_SUB=2'd1, S_DONE=2'd2.
//   Default width constant SERIES_W=8, shared with the series-sum block.
//  One sub-module: series_root_dp.
//   Holds R, C, N, the subtractor, the incrementer and the R>=C comparator.
//   Controls: load, step. Status: ge (R>=C), rz (R==0).
//  The controller FSM lives in series_root_finder. It drives load/step and
//   registers Exact.
// TESTING
//  1. Data_in=10, Start pulse -> Done after 6 edges; N_out=4, Rem_out=0, Exact=1.
//  2. Data_in=12 -> N_out=4, Rem_out=2, Exact=0; Busy high for exactly 6 cycles.
//  3. Data_in=0 -> Done after 2 edges; N_out=0, Rem_out=0, Exact=1.
//     Data_in=253 -> N_out=22, Exact=1.
//  4. Data_in=255 -> N_out=22, Rem_out=2, Exact=0; C never exceeds 23.
//  5. Start=1 with Data_in=10; change Data_in to 200 and re-pulse Start mid-SUB
//     -> ignored, result still N=4.
//     Then Rst_n low mid-SUB -> all outputs 0 immediately (asynchronous), state IDLE.
//  6. Start held high continuously with Data_in=6 -> back-to-back runs.
//     Each run: N=3, Exact=1, one Done pulse per run, one IDLE cycle between runs.

Source files
------------

// File: rtl/series_pkg.sv
// Shared constants for the series-sum / series-root blocks.
package series_pkg;

   localparam int unsigned SERIES_W = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SUB  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_SUB  = S_SUB,
      ST_DONE = S_DONE
   } state_t;

endpackage

// File: rtl/series_root_dp.sv
// Root-finder datapath: remainder R, next term C, count N, with R>=C compare.
module series_root_dp #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic         i_step,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_r,
   output logic [W-1:0] o_n,
   output logic         o_ge,
   output logic         o_rz
);

   logic [W-1:0] r_r;
   logic [W-1:0] r_c;
   logic [W-1:0] r_n;

   logic [W-1:0] w_diff;
   logic [W-1:0] w_c_inc;

   assign w_diff  = r_r - r_c;
   assign w_c_inc = r_c + W'(1);
   assign o_ge    = (r_r >= r_c);
   assign o_rz    = (r_r == '0);
   assign o_r     = r_r;
   assign o_n     = r_n;

   // Subtraction is only applied when guarded by o_ge, so R never wraps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_r <= '0;
         r_c <= '0;
         r_n <= '0;
      end else if (i_load) begin
         r_r <= i_data;
         r_c <= W'(1);
         r_n <= '0;
      end else if (i_step) begin
         r_r <= w_diff;
         r_n <= r_c;
         r_c <= w_c_inc;
      end
   end

endmodule

// File: rtl/series_root_finder.sv
// Finds the largest N with 1+..+N <= S, plus remainder and exact flag.
module series_root_finder
   import series_pkg::*;
#(
   parameter int unsigned W = SERIES_W
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         Start,
   input  logic [W-1:0] Data_in,
   output logic [W-1:0] N_out,
   output logic [W-1:0] Rem_out,
   output logic         Exact,
   output logic         Busy,
   output logic         Done
);

   state_t r_state;
   state_t w_next;
   logic   r_exact;
   logic   w_exact_d;
   logic   w_load;
   logic   w_step;
   logic   w_ge;
   logic   w_rz;

   series_root_dp #(.W(W)) u_dp (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_data  (Data_in),
      .o_r     (Rem_out),
      .o_n     (N_out),
      .o_ge    (w_ge),
      .o_rz    (w_rz)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= ST_IDLE;
         r_exact <= 1'b0;
      end else begin
         r_state <= w_next;
         r_exact <= w_exact_d;
      end
   end

   // Next-state and datapath control; unknown encodings fall back to IDLE.
   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_step    = 1'b0;
      w_exact_d = r_exact;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_load    = 1'b1;
               w_exact_d = 1'b0;
               w_next    = ST_SUB;
            end
         end
         ST_SUB: begin
            if (w_ge) begin
               w_step = 1'b1;
            end else begin
               w_exact_d = w_rz;
               w_next    = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign Exact = r_exact;
   assign Busy  = (r_state == ST_SUB) || (r_state == ST_DONE);
   assign Done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_series_root_finder.sv
// Scoreboard bench for series_root_finder: directed runs, monitor checks on Done.
module tb_series_root_finder;

   typedef struct packed {
      logic [7:0] n;
      logic [7:0] rem;
      logic       ex;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] data_in;
   logic [7:0] n_out;
   logic [7:0] rem_out;
   logic       exact;
   logic       busy;
   logic       done;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   max_c   = 0;

   series_root_finder #(.W(8)) dut (
      .Clk     (clk),
      .Rst_n   (rst_n),
      .Start   (start),
      .Data_in (data_in),
      .N_out   (n_out),
      .Rem_out (rem_out),
      .Exact   (exact),
      .Busy    (busy),
      .Done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Monitor: every Done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got a Done pulse, required none");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("n_out", int'(n_out), int'(e.n));
            chk("rem_out", int'(rem_out), int'(e.rem));
            chk("exact", int'(exact), int'(e.ex));
         end
      end
   end

   always @(negedge clk) begin
      if (busy && int'(dut.u_dp.r_c) > max_c) max_c = int'(dut.u_dp.r_c);
   end

   task automatic run(input int s, input int n, input int rem, input int ex,
                      input bit poke, input string nm);
      int k;
      int nbusy;
      int lat;
      q.push_back('{n: 8'(n), rem: 8'(rem), ex: 1'(ex)});
      @(negedge clk);
      data_in = 8'(s);
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 0; nbusy = 0; lat = 0;
      while (k < 300) begin
         @(negedge clk);
         k++;
         if (poke && k == 2) begin
            data_in = 8'd200;
            start   = 1'b1;
         end
         if (poke && k == 3) start = 1'b0;
         if (busy) nbusy++;
         if (done && lat == 0) lat = k;
         if (!busy) break;
      end
      chk({nm, "_latency"}, lat, n + 2);
      chk({nm, "_busy_cycles"}, nbusy, n + 2);
   endtask

   initial begin
      int k;
      int dones;
      int idle;
      int last_k;
      rst_n   = 1'b0;
      start   = 1'b0;
      data_in = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_n_out", int'(n_out), 0);
      chk("rst_rem_out", int'(rem_out), 0);
      chk("rst_exact", int'(exact), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(10, 4, 0, 1, 1'b0, "s10");
      run(12, 4, 2, 0, 1'b0, "s12");
      run(0, 0, 0, 1, 1'b0, "s0");
      run(1, 1, 0, 1, 1'b0, "s1");
      run(2, 1, 1, 0, 1'b0, "s2");
      run(253, 22, 0, 1, 1'b0, "s253");
      max_c = 0;
      run(255, 22, 2, 0, 1'b0, "s255");
      chk("s255_max_c", max_c, 23);
      run(10, 4, 0, 1, 1'b1, "s10_poke");

      // Asynchronous reset in the middle of SUB.
      @(negedge clk);
      data_in = 8'd100;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_n_out_nonzero", int'(n_out != 8'd0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_n_out", int'(n_out), 0);
      chk("mid_rst_rem_out", int'(rem_out), 0);
      chk("mid_rst_exact", int'(exact), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run(6, 3, 0, 1, 1'b0, "s6_after_rst");

      // Start held high: three back-to-back runs with one IDLE cycle between.
      repeat (3) q.push_back('{n: 8'd3, rem: 8'd0, ex: 1'b1});
      @(negedge clk);
      data_in = 8'd6;
      start   = 1'b1;
      dones = 0; idle = 0; k = 0; last_k = 0;
      while (dones < 3 && k < 200) begin
         @(negedge clk);
         k++;
         if (done) begin
            dones++;
            if (dones > 1) begin
               chk("b2b_idle_gap", idle, 1);
               chk("b2b_period", k - last_k, 6);
            end
            if (dones == 3) start = 1'b0;
            last_k = k;
            idle   = 0;
         end else if (!busy) begin
            idle++;
         end
      end
      chk("b2b_done_count", dones, 3);
      repeat (3) @(negedge clk);
      chk("b2b_stopped", int'(busy), 0);

      k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
